rgb2yuv_stream: RTL and testbench
=================================

# rgb2yuv_stream

Upstream front-end of `clahe_top`. Converts a 24-bit RGB video stream (BMP reader / sensor path) into the 8-bit Y/U/V stream with `href`/`vsync` that `clahe_top` consumes, using a fixed 3-stage pipeline with timing signals delayed to match. It also monitors input frame geometry and reports per-frame line/pixel errors. This lets CLAHE histogram statistics be trusted only on well-formed frames.

## Interface
- `WIDTH`, 1280, expected active pixels per line (href-high cycles).
- `HEIGHT`, 720, expected lines per frame (href pulses between vsync rising edges).
- `pclk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_r`, `in_g`, `in_b` in 8 each: pixel components, valid when `in_href`=1.
- `in_href` in 1: active pixel qualifier.
- `in_vsync` in 1: frame sync; rising edge = frame start.
- `out_y`, `out_u`, `out_v` out 8 each: converted pixel, to `clahe_top` `in_y/in_u/in_v`.
- `out_href`, `out_vsync` out 1 each: `in_href`/`in_vsync` delayed 3 cycles.
- `frame_done` out 1: 1-cycle pulse at each input vsync rise after the first one since reset.
- `geom_ok` out 1: valid with `frame_done`; 1 = closed frame had exactly `HEIGHT` lines, all `WIDTH` pixels.
- `last_lines` out 16: line count of the closed frame, held until next `frame_done`.
- `frame_cnt` out 16: number of `frame_done` pulses since reset, wraps 0xFFFF→0.

## Operation
- Arithmetic, BT.601 full-range integer approximation, floor (arithmetic) shift:
  - Y = (77R + 150G + 29B) >> 8
  - U = ((−43R − 85G + 128B) >>> 8) + 128
  - V = ((128R − 107G − 21B) >>> 8) + 128
- Products and sums held as 18-bit signed; result saturated to 0..255 before output (saturation is unreachable for valid 8-bit inputs but is required).
- Pipeline: S1 registers the 9 products; S2 registers the three sums; S3 shifts, offsets, saturates, registers outputs. `href`/`vsync` ride a matching 3-deep shift register.
- When pipelined href is 0, `out_y/u/v` are driven 0 (not held).
- Geometry monitor (input side, undelayed):
  - `pix_cnt` (16b) increments each `in_href`=1 cycle; at `in_href` falling edge, if `pix_cnt` ≠ `WIDTH` set sticky `hlen_err`; then `pix_cnt`←0 and `line_cnt`++.
  - At `in_vsync` rising edge: if `seen_frame`=1, pulse `frame_done`, `last_lines`←`line_cnt`, `geom_ok`←(`line_cnt`==`HEIGHT` && !`hlen_err`), `frame_cnt`++. Always then clear `line_cnt`, `hlen_err`; set `seen_frame`.
  - Lines before the first vsync rise after reset are discarded (no report).
  - Simultaneous href fall and vsync rise: the line is counted into the closing frame before the report.
  - `in_href` high during the vsync rise: the open partial line belongs to the new frame; `pix_cnt` is not cleared.
  - `pix_cnt` and `line_cnt` saturate at 0xFFFF.

## Timing
- Latency: `in_*` at cycle N → `out_*` at cycle N+3; throughput 1 pixel/cycle, no back-pressure.
- `frame_done`, `geom_ok`, `last_lines`, `frame_cnt` update the cycle after the sampled vsync rise (edge detected against a 1-cycle-delayed `in_vsync`). `geom_ok` is meaningful only while `frame_done`=1 but holds its value until the next report.
- Reset (any cycle, including mid-line): all outputs 0, pipeline and delay line cleared, counters 0, `hlen_err`=0, `seen_frame`=0, `in_vsync`/`in_href` delay registers 0 (a vsync already high when reset releases counts as a rise).

## Test plan
- Single pixels R,G,B=(255,255,255), (0,0,0), (255,0,0), (0,0,255) → out (Y,U,V)=(255,128,128), (0,128,128), (76,85,255), (28,255,107), each exactly 3 cycles later with `out_href`=1.
- Random RGB stream, 1000 pixels → every output matches the integer formulas; `out_href`/`out_vsync` equal inputs delayed 3; data 0 whenever `out_href`=0.
- Three well-formed frames (WIDTH=16, HEIGHT=4 override) → `frame_done` pulses 2×, `geom_ok`=1, `last_lines`=4, `frame_cnt`=1 then 2; no report on first vsync.
- Frame with one 15-pixel line, then frame with 5 lines → `geom_ok`=0 / `last_lines`=4, then `geom_ok`=0 / `last_lines`=5; following good frame → `geom_ok`=1.
- href falling edge and vsync rise in same cycle on 4th line → that frame reports `last_lines`=4, `geom_ok`=1.
- `rst` asserted mid-line for 1 cycle → next cycle all outputs 0; first subsequent vsync rise gives no `frame_done`, `frame_cnt` restarts from 0.

Source files
------------

// File: rtl/rgb2yuv_stream.sv
// RGB888 to YUV (BT.601 full range) with a fixed 3-stage pipeline and delayed href/vsync,
// plus an input-side frame geometry monitor reporting line/pixel errors per closed frame.
module rgb2yuv_stream #(
   parameter int WIDTH  = 1280,
   parameter int HEIGHT = 720
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic        in_href,
   input  logic        in_vsync,
   output logic [7:0]  out_y,
   output logic [7:0]  out_u,
   output logic [7:0]  out_v,
   output logic        out_href,
   output logic        out_vsync,
   output logic        frame_done,
   output logic        geom_ok,
   output logic [15:0] last_lines,
   output logic [15:0] frame_cnt
);

   localparam logic [15:0] WIDTH_C  = 16'(WIDTH);
   localparam logic [15:0] HEIGHT_C = 16'(HEIGHT);

   function automatic logic signed [17:0] mul(input logic [7:0] x, input logic signed [17:0] k);
      return $signed({10'd0, x}) * k;
   endfunction

   function automatic logic [7:0] sat8(input logic signed [17:0] s, input logic add_off);
      logic signed [17:0] t;
      t = (s >>> 8) + (add_off ? 18'sd128 : 18'sd0);
      if (t < 18'sd0)
         return 8'd0;
      else if (t > 18'sd255)
         return 8'd255;
      else
         return t[7:0];
   endfunction

   // ---------------- datapath ----------------
   // product order: Y(R,G,B), U(R,G,B), V(R,G,B)
   logic signed [17:0] p_q [9];
   logic signed [17:0] s_q [3];
   logic [2:0]         href_pipe_q;
   logic [2:0]         vsync_pipe_q;
   logic [7:0]         y_q, u_q, v_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) p_q[i] <= '0;
         for (int i = 0; i < 3; i++) s_q[i] <= '0;
         href_pipe_q  <= '0;
         vsync_pipe_q <= '0;
         y_q          <= '0;
         u_q          <= '0;
         v_q          <= '0;
      end else begin
         p_q[0] <= mul(in_r,  18'sd77);
         p_q[1] <= mul(in_g,  18'sd150);
         p_q[2] <= mul(in_b,  18'sd29);
         p_q[3] <= mul(in_r, -18'sd43);
         p_q[4] <= mul(in_g, -18'sd85);
         p_q[5] <= mul(in_b,  18'sd128);
         p_q[6] <= mul(in_r,  18'sd128);
         p_q[7] <= mul(in_g, -18'sd107);
         p_q[8] <= mul(in_b, -18'sd21);

         s_q[0] <= p_q[0] + p_q[1] + p_q[2];
         s_q[1] <= p_q[3] + p_q[4] + p_q[5];
         s_q[2] <= p_q[6] + p_q[7] + p_q[8];

         // href_pipe_q[1] is the qualifier of the sample now leaving S2
         y_q <= href_pipe_q[1] ? sat8(s_q[0], 1'b0) : 8'd0;
         u_q <= href_pipe_q[1] ? sat8(s_q[1], 1'b1) : 8'd0;
         v_q <= href_pipe_q[1] ? sat8(s_q[2], 1'b1) : 8'd0;

         href_pipe_q  <= {href_pipe_q[1:0], in_href};
         vsync_pipe_q <= {vsync_pipe_q[1:0], in_vsync};
      end
   end

   assign out_y     = y_q;
   assign out_u     = u_q;
   assign out_v     = v_q;
   assign out_href  = href_pipe_q[2];
   assign out_vsync = vsync_pipe_q[2];

   // ---------------- geometry monitor ----------------
   logic        href_q, vsync_q;
   logic [15:0] pix_q, pix_d;
   logic [15:0] line_q, line_d;
   logic        hlen_q, hlen_d;
   logic        seen_q, seen_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic [15:0] last_q, last_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic        href_fall, vs_rise;
   logic [15:0] line_eff;
   logic        hlen_eff;

   assign href_fall = href_q & ~in_href;
   assign vs_rise   = in_vsync & ~vsync_q;

   always_comb begin
      pix_d    = pix_q;
      line_d   = line_q;
      hlen_d   = hlen_q;
      seen_d   = seen_q;
      done_d   = 1'b0;
      ok_d     = ok_q;
      last_d   = last_q;
      fcnt_d   = fcnt_q;
      line_eff = line_q;
      hlen_eff = hlen_q;

      if (in_href)
         pix_d = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
      else if (href_fall)
         pix_d = '0;

      // a line ending in the vsync-rise cycle still belongs to the closing frame
      if (href_fall) begin
         if (pix_q != WIDTH_C) hlen_eff = 1'b1;
         line_eff = (line_q == 16'hFFFF) ? line_q : line_q + 16'd1;
      end
      line_d = line_eff;
      hlen_d = hlen_eff;

      if (vs_rise) begin
         if (seen_q) begin
            done_d = 1'b1;
            last_d = line_eff;
            ok_d   = (line_eff == HEIGHT_C) && !hlen_eff;
            fcnt_d = fcnt_q + 16'd1;
         end
         line_d = '0;
         hlen_d = 1'b0;
         seen_d = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         href_q  <= 1'b0;
         vsync_q <= 1'b0;
         pix_q   <= '0;
         line_q  <= '0;
         hlen_q  <= 1'b0;
         seen_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         last_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         href_q  <= in_href;
         vsync_q <= in_vsync;
         pix_q   <= pix_d;
         line_q  <= line_d;
         hlen_q  <= hlen_d;
         seen_q  <= seen_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         last_q  <= last_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign frame_done = done_q;
   assign geom_ok    = ok_q;
   assign last_lines = last_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_rgb2yuv_stream.sv
// Directed bench for rgb2yuv_stream: conversion vectors, random stream against a formula model,
// and frame geometry reporting with a 16x4 frame override.
module tb_rgb2yuv_stream;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  in_r, in_g, in_b;
   logic        in_href, in_vsync;
   logic [7:0]  out_y, out_u, out_v;
   logic        out_href, out_vsync;
   logic        frame_done, geom_ok;
   logic [15:0] last_lines, frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] y, u, v;
      logic       href, vsync;
   } exp_t;

   always #5 pclk = ~pclk;

   rgb2yuv_stream #(.WIDTH(16), .HEIGHT(4)) dut (
      .pclk(pclk), .rst(rst),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .in_href(in_href), .in_vsync(in_vsync),
      .out_y(out_y), .out_u(out_u), .out_v(out_v),
      .out_href(out_href), .out_vsync(out_vsync),
      .frame_done(frame_done), .geom_ok(geom_ok),
      .last_lines(last_lines), .frame_cnt(frame_cnt)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [7:0] clamp(input int x);
      if (x < 0) return 8'd0;
      if (x > 255) return 8'd255;
      return 8'(x);
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) begin
         in_href = 1'b1;
         in_r = 8'(i * 7); in_g = 8'(i * 13); in_b = 8'(i * 3);
         tick();
      end
      in_href = 1'b0;
      tick(); tick();
   endtask

   task automatic send_lines(input int cnt, input int n);
      for (int i = 0; i < cnt; i++) send_line(n);
   endtask

   task automatic vsync_pulse(output logic d, output logic o, output logic [15:0] l,
                              output logic [15:0] c, output logic dn);
      in_vsync = 1'b1;
      tick();
      d = frame_done; o = geom_ok; l = last_lines; c = frame_cnt;
      tick();
      dn = frame_done;
      in_vsync = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_href = 1'b1; in_vsync = 1'b1;
      in_r = 8'd200; in_g = 8'd100; in_b = 8'd50;
      tick(); tick();
      checks++; if ({out_y, out_u, out_v} !== 24'd0) begin errors++; $display("FAIL reset_yuv: got %h expected 000000", {out_y, out_u, out_v}); end
      checks++; if ({out_href, out_vsync} !== 2'b00) begin errors++; $display("FAIL reset_sync: got %b expected 00", {out_href, out_vsync}); end
      checks++; if ({frame_done, geom_ok} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {frame_done, geom_ok}); end
      checks++; if (last_lines !== 16'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", last_lines, frame_cnt); end
      rst = 1'b0; in_href = 1'b0; in_vsync = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      tick(); tick(); tick();
   endtask

   task automatic test_single_pixels();
      logic [7:0] vr[4] = '{8'd255, 8'd0, 8'd255, 8'd0};
      logic [7:0] vg[4] = '{8'd255, 8'd0, 8'd0,   8'd0};
      logic [7:0] vb[4] = '{8'd255, 8'd0, 8'd0,   8'd255};
      logic [7:0] ey[4] = '{8'd255, 8'd0,   8'd76,  8'd28};
      logic [7:0] eu[4] = '{8'd128, 8'd128, 8'd85,  8'd255};
      logic [7:0] ev[4] = '{8'd128, 8'd128, 8'd255, 8'd107};
      for (int i = 0; i < 4; i++) begin
         in_r = vr[i]; in_g = vg[i]; in_b = vb[i]; in_href = 1'b1;
         tick();
         in_r = '0; in_g = '0; in_b = '0; in_href = 1'b0;
         tick();
         checks++; if (out_href !== 1'b0) begin errors++; $display("FAIL pix_early[%0d]: out_href got %b expected 0", i, out_href); end
         tick();
         checks++; if (out_href !== 1'b1) begin errors++; $display("FAIL pix_href[%0d]: got %b expected 1", i, out_href); end
         checks++; if (out_y !== ey[i]) begin errors++; $display("FAIL pix_y[%0d]: got %0d expected %0d", i, out_y, ey[i]); end
         checks++; if (out_u !== eu[i]) begin errors++; $display("FAIL pix_u[%0d]: got %0d expected %0d", i, out_u, eu[i]); end
         checks++; if (out_v !== ev[i]) begin errors++; $display("FAIL pix_v[%0d]: got %0d expected %0d", i, out_v, ev[i]); end
         tick();
         checks++; if (out_href !== 1'b0 || out_y !== 8'd0) begin errors++; $display("FAIL pix_after[%0d]: href/y got %b/%0d expected 0/0", i, out_href, out_y); end
      end
   endtask

   task automatic test_random_stream();
      exp_t q[$];
      exp_t e, o;
      int   r, g, b;
      for (int n = 0; n < 1000; n++) begin
         in_r = 8'($urandom_range(0, 255));
         in_g = 8'($urandom_range(0, 255));
         in_b = 8'($urandom_range(0, 255));
         in_href  = ($urandom_range(0, 3) != 0);
         in_vsync = ($urandom_range(0, 15) == 0);
         r = int'(in_r); g = int'(in_g); b = int'(in_b);
         e.href  = in_href;
         e.vsync = in_vsync;
         e.y = in_href ? clamp((77 * r + 150 * g + 29 * b) >>> 8) : 8'd0;
         e.u = in_href ? clamp(((-43 * r - 85 * g + 128 * b) >>> 8) + 128) : 8'd0;
         e.v = in_href ? clamp(((128 * r - 107 * g - 21 * b) >>> 8) + 128) : 8'd0;
         q.push_back(e);
         tick();
         if (q.size() == 3) begin
            o = q.pop_front();
            checks++;
            if (out_y !== o.y || out_u !== o.u || out_v !== o.v || out_href !== o.href || out_vsync !== o.vsync) begin
               errors++;
               $display("FAIL rand[%0d]: got y%0d u%0d v%0d h%b vs%b expected y%0d u%0d v%0d h%b vs%b",
                        n, out_y, out_u, out_v, out_href, out_vsync, o.y, o.u, o.v, o.href, o.vsync);
            end
         end
      end
      in_href = 1'b0; in_vsync = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_frames();
      logic d, o, dn;
      logic [15:0] l, c;
      do_reset();
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b0 || c !== 16'd0) begin errors++; $display("FAIL first_vsync: done/cnt got %b/%0d expected 0/0", d, c); end
      for (int f = 1; f <= 2; f++) begin
         send_lines(4, 16);
         vsync_pulse(d, o, l, c, dn);
         checks++;
         if (d !== 1'b1 || o !== 1'b1 || l !== 16'd4 || c !== 16'(f) || dn !== 1'b0) begin
            errors++;
            $display("FAIL good_frame[%0d]: done/ok/lines/cnt/next got %b/%b/%0d/%0d/%b expected 1/1/4/%0d/0", f, d, o, l, c, dn, f);
         end
      end
      send_lines(4, 16);
   endtask

   task automatic test_geom_errors();
      logic d, o, dn;
      logic [15:0] l, c;
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b1 || l !== 16'd4 || c !== 16'd3) begin errors++; $display("FAIL frame3: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/1/4/3", d, o, l, c); end
      send_line(16); send_line(15); send_line(16); send_line(16);
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b0 || l !== 16'd4 || c !== 16'd4) begin errors++; $display("FAIL short_line: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/0/4/4", d, o, l, c); end
      tick();
      checks++; if (geom_ok !== 1'b0 || last_lines !== 16'd4) begin errors++; $display("FAIL hold: ok/lines got %b/%0d expected 0/4", geom_ok, last_lines); end
      send_lines(5, 16);
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b0 || l !== 16'd5 || c !== 16'd5) begin errors++; $display("FAIL five_lines: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/0/5/5", d, o, l, c); end
      send_lines(4, 16);
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b1 || l !== 16'd4 || c !== 16'd6) begin errors++; $display("FAIL recover: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/1/4/6", d, o, l, c); end
   endtask

   task automatic test_simultaneous_edges();
      logic d, o, dn;
      logic [15:0] l, c;
      send_lines(3, 16);
      in_href = 1'b1;
      repeat (16) tick();
      in_href = 1'b0; in_vsync = 1'b1;
      tick();
      checks++; if (frame_done !== 1'b1 || geom_ok !== 1'b1 || last_lines !== 16'd4 || frame_cnt !== 16'd7) begin errors++; $display("FAIL fall_and_rise: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/1/4/7", frame_done, geom_ok, last_lines, frame_cnt); end
      tick();
      in_vsync = 1'b0;
      tick();
      // partial line straddling the vsync rise: 8 + 1 + 7 pixels belong to the new frame
      send_lines(3, 16);
      in_href = 1'b1;
      repeat (8) tick();
      in_vsync = 1'b1;
      tick();
      checks++; if (frame_done !== 1'b1 || geom_ok !== 1'b0 || last_lines !== 16'd3 || frame_cnt !== 16'd8) begin errors++; $display("FAIL href_in_rise: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/0/3/8", frame_done, geom_ok, last_lines, frame_cnt); end
      in_vsync = 1'b0;
      repeat (7) tick();
      in_href = 1'b0;
      tick(); tick();
      send_lines(3, 16);
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b1 || l !== 16'd4 || c !== 16'd9) begin errors++; $display("FAIL straddle_frame: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/1/4/9", d, o, l, c); end
   endtask

   task automatic test_reset_mid_line();
      logic d, o, dn;
      logic [15:0] l, c;
      in_r = 8'd90; in_g = 8'd180; in_b = 8'd30; in_href = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; in_href = 1'b0;
      checks++; if ({out_y, out_u, out_v, out_href, out_vsync} !== 26'd0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", {out_y, out_u, out_v, out_href, out_vsync}); end
      checks++; if (frame_done !== 1'b0 || geom_ok !== 1'b0 || last_lines !== 16'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_mon: done/ok/lines/cnt got %b/%b/%0d/%0d expected 0/0/0/0", frame_done, geom_ok, last_lines, frame_cnt); end
      tick(); tick();
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b0 || c !== 16'd0) begin errors++; $display("FAIL rst_first_vsync: done/cnt got %b/%0d expected 0/0", d, c); end
      send_lines(4, 16);
      vsync_pulse(d, o, l, c, dn);
      checks++; if (d !== 1'b1 || o !== 1'b1 || l !== 16'd4 || c !== 16'd1) begin errors++; $display("FAIL rst_restart: done/ok/lines/cnt got %b/%b/%0d/%0d expected 1/1/4/1", d, o, l, c); end
   endtask

   initial begin
      rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      test_reset();
      test_single_pixels();
      test_random_stream();
      test_frames();
      test_geom_errors();
      test_simultaneous_edges();
      test_reset_mid_line();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
